// File: rtl/pio_edge_irq_pkg.sv
// Shared constants for the parametrised edge-capture interrupt input port.
// Holds the register address map used by pio_edge_irq_in and its bench.
package pio_edge_irq_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;  // conditioned input data (R)
  localparam logic [2:0] ADDR_RISE = 3'd1;  // rising-edge enable (RW)
  localparam logic [2:0] ADDR_MASK = 3'd2;  // interrupt mask (RW)
  localparam logic [2:0] ADDR_EDGE = 3'd3;  // edge capture (R, W1C)
  localparam logic [2:0] ADDR_FALL = 3'd4;  // falling-edge enable (RW)
  localparam logic [2:0] ADDR_DBTH = 3'd5;  // debounce threshold (RW)

endpackage

// File: rtl/pio_db_filter.sv
// Single-bit debounce filter.
// The filtered output follows the synchronised input only after the input
// has disagreed with it for thresh+1 consecutive cycles. The threshold is
// sampled live, so a new value applies to any count already in flight.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   sync_in  in   synchronised input bit
//   thresh   in   DB_W-bit threshold
//   filt     out  filtered bit (registered)
module pio_db_filter #(
  parameter int DB_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sync_in,
  input  logic [DB_W-1:0] thresh,
  output logic            filt
);

  logic [DB_W-1:0] cnt_r;
  logic            filt_r;

  // Count consecutive disagreeing cycles; flip the filtered bit at threshold
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= '0;
      filt_r <= 1'b0;
    end else if (sync_in == filt_r) begin
      cnt_r  <= '0;
    end else if (cnt_r == thresh) begin
      filt_r <= sync_in;
      cnt_r  <= '0;
    end else begin
      cnt_r  <= cnt_r + DB_W'(1'b1);
    end
  end

  assign filt = filt_r;

endmodule

// File: rtl/pio_edge_irq_in.sv
// Parametrised edge-capture interrupt input port on an Avalon-MM slave.
// Each of WIDTH asynchronous inputs passes through a SYNC_STAGES-deep
// synchroniser (and optionally a debounce filter); selected rising/falling
// edges set write-1-to-clear capture bits, and any unmasked capture bit
// raises the level interrupt.
// Optional feature: define PIO_EDGE_IRQ_DEBOUNCE_EN to add a per-channel
// debounce filter and the threshold register at address 5.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   address     in   3-bit register select
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   WIDTH-bit write data
//   in_port     in   WIDTH asynchronous external inputs
//   readdata    out  WIDTH-bit registered read data (1-cycle latency)
//   irq         out  active-high level interrupt
module pio_edge_irq_in
  import pio_edge_irq_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 4,
  parameter int DB_DEFAULT  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] cond_s;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] rise_en_r;
  logic [WIDTH-1:0] fall_en_r;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] edge_capture_r;
  logic [WIDTH-1:0] det_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] dbth_rd_s;
  logic [WIDTH-1:0] rd_nxt_s;
  logic [WIDTH-1:0] readdata_r;
  logic             wr_s;

  assign wr_s = chipselect & ~write_n;

  // Synchroniser: index 0 takes the raw input, the last stage is "sync"
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
  logic [DB_W-1:0]  dbth_r;
  logic [WIDTH-1:0] filt_s;

  // Debounce threshold register
  always_ff @(posedge clk) begin
    if (reset) begin
      dbth_r <= DB_W'(DB_DEFAULT);
    end else if (wr_s && (address == ADDR_DBTH)) begin
      dbth_r <= writedata[DB_W-1:0];
    end else begin
      dbth_r <= dbth_r;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_filt
    pio_db_filter #(.DB_W(DB_W)) u_filt (
      .clk     (clk),
      .reset   (reset),
      .sync_in (sync_s[gi]),
      .thresh  (dbth_r),
      .filt    (filt_s[gi])
    );
  end

  // Zero-extend the threshold onto the read bus
  always_comb begin
    dbth_rd_s            = '0;
    dbth_rd_s[DB_W-1:0]  = dbth_r;
  end

  assign cond_s = filt_s;
`else
  assign cond_s    = sync_s;
  assign dbth_rd_s = '0;
`endif

  // Software-visible control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_en_r  <= '0;
      fall_en_r  <= '0;
      irq_mask_r <= '0;
    end else if (wr_s) begin
      case (address)
        ADDR_RISE: rise_en_r  <= writedata;
        ADDR_MASK: irq_mask_r <= writedata;
        ADDR_FALL: fall_en_r  <= writedata;
        default:   rise_en_r  <= rise_en_r;
      endcase
    end else begin
      rise_en_r  <= rise_en_r;
    end
  end

  // Edge detect against the previous conditioned value
  assign det_s = (cond_s & ~prev_r & rise_en_r) | (~cond_s & prev_r & fall_en_r);
  assign clr_s = (wr_s && (address == ADDR_EDGE)) ? writedata : '0;

  // Capture register: OR-ing det after the clear makes a same-cycle edge win
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r         <= '0;
      edge_capture_r <= '0;
    end else begin
      prev_r         <= cond_s;
      edge_capture_r <= (edge_capture_r & ~clr_s) | det_s;
    end
  end

  // Read mux, registered every cycle independent of chipselect
  always_comb begin
    rd_nxt_s = '0;
    case (address)
      ADDR_DATA: rd_nxt_s = cond_s;
      ADDR_RISE: rd_nxt_s = rise_en_r;
      ADDR_MASK: rd_nxt_s = irq_mask_r;
      ADDR_EDGE: rd_nxt_s = edge_capture_r;
      ADDR_FALL: rd_nxt_s = fall_en_r;
      ADDR_DBTH: rd_nxt_s = dbth_rd_s;
      default:   rd_nxt_s = '0;
    endcase
  end

  // Read data register
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_r <= '0;
    end else begin
      readdata_r <= rd_nxt_s;
    end
  end

  assign readdata = readdata_r;
  assign irq      = |(edge_capture_r & irq_mask_r);

endmodule

// File: tb/tb_pio_edge_irq_in.sv
// Scoreboard bench for pio_edge_irq_in. A reference model, run at every
// rising clock edge, pushes the expected readdata and irq into queues; a
// monitor on the falling edge pops and compares them against the DUT.
module tb_pio_edge_irq_in;

  localparam int W   = 6;
  localparam int S   = 2;
  localparam int DBW = 4;
  localparam int DBD = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [W-1:0] writedata;
  logic [W-1:0] in_port;
  logic [W-1:0] readdata;
  logic         irq;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pio_edge_irq_in #(
    .WIDTH(W), .SYNC_STAGES(S), .DB_W(DBW), .DB_DEFAULT(DBD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  // Reference model state
  logic [W-1:0]   in_hist[$];    // inputs sampled at each edge since reset
  logic [W-1:0]   sync_hist[$];  // synchronised value after each edge
  logic [W-1:0]   m_cond, m_prev, m_edge, m_mask, m_rise, m_fall;
  logic [DBW-1:0] m_th;

  // Scoreboard queues
  logic [W-1:0] exp_rd_q[$];
  logic [2:0]   exp_addr_q[$];
  logic         exp_irq_q[$];

  task automatic model_step();
    logic [W-1:0]   det, rd, clr, sync_v, new_cond;
    logic [DBW-1:0] th_old;
    logic           wr, ok, v;
    int             idx;
    rd = '0;
    if (reset) begin
      in_hist.delete();
      sync_hist.delete();
      m_cond = '0; m_prev = '0; m_edge = '0;
      m_mask = '0; m_rise = '0; m_fall = '0;
      m_th   = DBW'(DBD);
    end else begin
      det = (m_cond & ~m_prev & m_rise) | (~m_cond & m_prev & m_fall);
      case (address)
        3'd0: rd = m_cond;
        3'd1: rd = m_rise;
        3'd2: rd = m_mask;
        3'd3: rd = m_edge;
        3'd4: rd = m_fall;
`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
        3'd5: rd = W'(m_th);
`endif
        default: rd = '0;
      endcase
      wr     = chipselect && !write_n;
      clr    = (wr && address == 3'd3) ? writedata : '0;
      th_old = m_th;
      if (wr) begin
        case (address)
          3'd1: m_rise = writedata;
          3'd2: m_mask = writedata;
          3'd4: m_fall = writedata;
          3'd5: m_th   = writedata[DBW-1:0];
          default: ;
        endcase
      end
      m_edge = (m_edge & ~clr) | det;
      in_hist.push_back(in_port);
      sync_v = (in_hist.size() >= S) ? in_hist[in_hist.size()-S] : '0;
`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
      // Filtered bit flips once the last th+1 sync values all disagree with it
      new_cond = m_cond;
      for (int i = 0; i < W; i++) begin
        ok = 1'b1;
        for (int j = 0; j <= int'(th_old); j++) begin
          idx = sync_hist.size() - 1 - j;
          v   = (idx >= 0) ? sync_hist[idx][i] : 1'b0;
          if (v == m_cond[i]) ok = 1'b0;
        end
        if (ok) new_cond[i] = ~m_cond[i];
      end
`else
      new_cond = sync_v;
      if (th_old != m_th) m_th = m_th;
`endif
      sync_hist.push_back(sync_v);
      m_prev = m_cond;
      m_cond = new_cond;
    end
    exp_rd_q.push_back(rd);
    exp_addr_q.push_back(address);
    exp_irq_q.push_back(|(m_edge & m_mask));
  endtask

  // Model process: advance the reference model at every rising edge
  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compare DUT outputs against queued expectations mid-cycle
  initial begin
    logic [W-1:0] e_rd;
    logic [2:0]   e_a;
    logic         e_irq;
    forever begin
      @(negedge clk);
      if (exp_rd_q.size() > 0) begin
        e_rd = exp_rd_q.pop_front();
        e_a  = exp_addr_q.pop_front();
        n_checks++;
        if (readdata === e_rd) n_pass++;
        else $display("FAIL readdata addr=%0d got=%h expected=%h t=%0t", e_a, readdata, e_rd, $time);
      end
      if (exp_irq_q.size() > 0) begin
        e_irq = exp_irq_q.pop_front();
        n_checks++;
        if (irq === e_irq) n_pass++;
        else $display("FAIL irq got=%b expected=%b t=%0t", irq, e_irq, $time);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    cyc();
    chipselect = 1'b0;
  endtask

  initial begin
    logic [2:0] a;
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    cyc(2);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) rd(3'(i));

    // Rising edge on bit 0 with mask bit 0
    wr(3'd1, 6'h3F); wr(3'd2, 6'h01);
    in_port = 6'h01; cyc(4);
    rd(3'd3); rd(3'd0);

    // Falling-only capture on bit 2
    wr(3'd3, 6'h3F); wr(3'd1, 6'h00); wr(3'd4, 6'h04);
    in_port = 6'h04; cyc(5); in_port = 6'h00; cyc(4);
    rd(3'd3);

    // Two captures pending, clear only bit 0
    wr(3'd1, 6'h01); in_port = 6'h01; cyc(4);
    wr(3'd2, 6'h05); rd(3'd3); wr(3'd3, 6'h01); rd(3'd3);

    // New edge on bit 0 in the same cycle as its W1C
    in_port = 6'h00; cyc(4); wr(3'd3, 6'h3F);
    in_port = 6'h01; cyc(2); wr(3'd3, 6'h01); rd(3'd3); rd(3'd3);

`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
    // Short glitch rejected, longer pulse accepted late
    wr(3'd5, 6'h03); wr(3'd1, 6'h3F); wr(3'd2, 6'h3F); wr(3'd3, 6'h3F);
    in_port = 6'h03; cyc(3); in_port = 6'h01; cyc(10); rd(3'd3);
    in_port = 6'h03; cyc(6); in_port = 6'h01; cyc(10); rd(3'd3); rd(3'd5);
`endif

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      case ($urandom_range(0, 4))
        0: begin
          a = 3'($urandom_range(0, 7));
`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
          if (a == 3'd5) a = 3'd6;
`endif
          wr(a, W'($urandom));
        end
        1:       wr(3'd3, W'($urandom));
        default: rd(3'($urandom_range(0, 7)));
      endcase
    end

    // Reset in the middle of pending captures
    wr(3'd1, 6'h3F); wr(3'd4, 6'h3F); wr(3'd2, 6'h3F);
    in_port = 6'h00; cyc(20); in_port = 6'h3F; cyc(20);
    rd(3'd3);
    address = 3'd3;
    reset = 1'b1; cyc(1); reset = 1'b0;
    rd(3'd3); rd(3'd2);
    cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
